// File: rtl/thor2024_fc_tracker.sv
// thor2024_fc_tracker: tracks in-flight flow-control instructions, retires them in order,
// and squashes younger entries with a one-cycle fetch redirect on mispredict.
module thor2024_fc_tracker #(
   parameter int DEPTH = 4,
   parameter int TAGW  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dec_v,
   input  logic            dec_fc,
   output logic            dec_rdy,
   output logic [TAGW-1:0] dec_tag,
   input  logic            res_v,
   input  logic [TAGW-1:0] res_tag,
   input  logic            res_mispred,
   input  logic [31:0]     res_tgt,
   output logic            redirect_v,
   output logic [31:0]     redirect_pc,
   output logic            stall,
   output logic [TAGW:0]   count
);
   logic [DEPTH-1:0] vld, dn, vld_n, dn_n;
   logic [TAGW-1:0]  head, tail, off_r, off_i;
   logic [TAGW:0]    cnt;
   logic             full, res_hit, mis_hit, alloc, retire;
   assign full    = cnt == (TAGW+1)'(DEPTH);
   assign res_hit = res_v & vld[res_tag];
   assign mis_hit = res_hit & res_mispred;
   assign dec_rdy = !dec_fc | (!full & !mis_hit);
   assign alloc   = dec_v & dec_fc & dec_rdy;
   assign retire  = vld[head] & dn[head];
   assign off_r   = res_tag - head;
   assign dec_tag = tail;
   assign stall   = full;
   assign count   = cnt;
   // Age is measured as distance from head, so "younger than res_tag" is a larger offset.
   always_comb begin
      vld_n = vld;
      dn_n  = dn;
      off_i = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off_i = TAGW'(i) - head;
         if (res_hit && res_tag == TAGW'(i)) dn_n[i] = 1'b1;
         if (mis_hit && off_i > off_r) begin
            vld_n[i] = 1'b0;
            dn_n[i]  = 1'b0;
         end
      end
      if (retire) begin
         vld_n[head] = 1'b0;
         dn_n[head]  = 1'b0;
      end
      if (alloc) begin
         vld_n[tail] = 1'b1;
         dn_n[tail]  = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld         <= '0;
         dn          <= '0;
         head        <= '0;
         tail        <= '0;
         cnt         <= '0;
         redirect_v  <= 1'b0;
         redirect_pc <= '0;
      end else begin
         vld         <= vld_n;
         dn          <= dn_n;
         head        <= head + TAGW'(retire);
         tail        <= mis_hit ? res_tag + TAGW'(1) : tail + TAGW'(alloc);
         cnt         <= mis_hit ? (TAGW+1)'(off_r) + (TAGW+1)'(1) - (TAGW+1)'(retire)
                                : cnt + (TAGW+1)'(alloc) - (TAGW+1)'(retire);
         redirect_v  <= mis_hit;
         redirect_pc <= mis_hit ? res_tgt : redirect_pc;
      end
   end
endmodule

// File: tb/tb_thor2024_fc_tracker.sv
// tb_thor2024_fc_tracker: directed checks of allocation, out-of-order resolve,
// mispredict squash, wrap-around and reset behaviour.
module tb_thor2024_fc_tracker;
   logic        clk = 1'b0;
   logic        rst_n, dec_v, dec_fc, dec_rdy, res_v, res_mispred, redirect_v, stall;
   logic [1:0]  dec_tag, res_tag;
   logic [31:0] res_tgt, redirect_pc;
   logic [2:0]  count;
   int checks = 0;
   int failures = 0;

   thor2024_fc_tracker #(.DEPTH(4), .TAGW(2)) dut (
      .clk(clk), .rst_n(rst_n), .dec_v(dec_v), .dec_fc(dec_fc), .dec_rdy(dec_rdy),
      .dec_tag(dec_tag), .res_v(res_v), .res_tag(res_tag), .res_mispred(res_mispred),
      .res_tgt(res_tgt), .redirect_v(redirect_v), .redirect_pc(redirect_pc),
      .stall(stall), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 0; dec_v = 1; dec_fc = 1; res_v = 1; res_tag = 2; res_mispred = 1; res_tgt = 32'h1234;
      tick; tick;
      dec_fc = 0; res_v = 0; res_mispred = 0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_stall", stall, 0);
      chk("rst_tag", dec_tag, 0);
      chk("rst_redir_v", redirect_v, 0);
      chk("rst_redir_pc", redirect_pc, 0);
      // fill
      rst_n = 1; dec_fc = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fill_tag", dec_tag, i);
         chk("fill_rdy", dec_rdy, 1);
         tick;
      end
      chk("fill_count", count, 4);
      chk("fill_stall", stall, 1);
      chk("fill_rdy_fc", dec_rdy, 0);
      dec_fc = 0;
      #1;
      chk("fill_rdy_nonfc", dec_rdy, 1);
      chk("fill_tag_wrap", dec_tag, 0);
      // mispredict on tag 1 while full
      dec_fc = 1; res_v = 1; res_tag = 1; res_mispred = 1; res_tgt = 32'h0000_1A40;
      tick;
      dec_fc = 0; res_v = 0; res_mispred = 0;
      #1;
      chk("mis_redir_v", redirect_v, 1);
      chk("mis_redir_pc", redirect_pc, 32'h0000_1A40);
      chk("mis_count", count, 2);
      chk("mis_stall", stall, 0);
      chk("mis_tail", dec_tag, 2);
      tick;
      chk("mis_pulse_end", redirect_v, 0);
      chk("mis_pc_hold", redirect_pc, 32'h0000_1A40);
      // tag 1 already done via its mispredict; resolve head 0
      res_v = 1; res_tag = 0;
      tick;
      res_v = 0;
      #1;
      chk("drain_c2", count, 2);
      tick;
      chk("drain_c1", count, 1);
      tick;
      chk("drain_c0", count, 0);
      chk("drain_tail", dec_tag, 2);
      // mispredict colliding with fc decode
      dec_fc = 1;
      for (int i = 0; i < 3; i++) begin
         chk("col_tag", dec_tag, (i + 2) % 4);
         tick;
      end
      res_v = 1; res_tag = 3; res_mispred = 1; res_tgt = 32'h0000_2000;
      #1;
      chk("col_rdy", dec_rdy, 0);
      tick;
      dec_fc = 0; res_v = 0; res_mispred = 0;
      #1;
      chk("col_count", count, 2);
      chk("col_tail", dec_tag, 0);
      chk("col_redir_v", redirect_v, 1);
      chk("col_redir_pc", redirect_pc, 32'h0000_2000);
      // resolution to squashed tag 0 ignored
      res_v = 1; res_tag = 0; res_mispred = 1; res_tgt = 32'h0000_5555;
      tick;
      res_v = 0; res_mispred = 0;
      #1;
      chk("stale_redir_v", redirect_v, 0);
      chk("stale_count", count, 2);
      chk("stale_pc", redirect_pc, 32'h0000_2000);
      rst_n = 0;
      tick;
      rst_n = 1;
      // out-of-order resolve
      dec_fc = 1;
      for (int i = 0; i < 3; i++) begin
         chk("ooo_tag", dec_tag, i);
         tick;
      end
      dec_fc = 0; res_v = 1; res_tag = 2;
      tick;
      chk("ooo_r2", count, 3);
      res_tag = 1;
      tick;
      chk("ooo_r1", count, 3);
      res_tag = 0;
      tick;
      res_v = 0;
      #1;
      chk("ooo_r0", count, 3);
      tick;
      chk("ooo_ret0", count, 2);
      tick;
      chk("ooo_ret1", count, 1);
      tick;
      chk("ooo_ret2", count, 0);
      rst_n = 0;
      tick;
      rst_n = 1;
      // wrap: six alloc/retire rounds
      for (int k = 0; k < 6; k++) begin
         dec_fc = 1;
         #1;
         chk("wrap_tag", dec_tag, k % 4);
         tick;
         dec_fc = 0; res_v = 1; res_tag = 2'(k % 4);
         tick;
         res_v = 0;
         tick;
         chk("wrap_count", count, 0);
      end
      dec_fc = 1;
      tick;
      dec_fc = 0; res_v = 1; res_tag = 3; res_mispred = 1; res_tgt = 32'h0000_7777;
      tick;
      res_v = 0; res_mispred = 0;
      #1;
      chk("wrap_stale_count", count, 1);
      chk("wrap_stale_redir", redirect_v, 0);
      chk("wrap_stale_tail", dec_tag, 3);
      // build count 3 with nonzero redirect_pc, then reset against a mispredict
      dec_fc = 1;
      tick; tick; tick;
      chk("pre_rst_stall", stall, 1);
      dec_fc = 0; res_v = 1; res_tag = 3; res_mispred = 1; res_tgt = 32'h0000_4444;
      tick;
      res_v = 0; res_mispred = 0;
      #1;
      chk("pre_rst_count", count, 2);
      chk("pre_rst_pc", redirect_pc, 32'h0000_4444);
      dec_fc = 1;
      tick;
      dec_fc = 0;
      #1;
      chk("pre_rst_count3", count, 3);
      rst_n = 0; dec_fc = 1; res_v = 1; res_tag = 2; res_mispred = 1; res_tgt = 32'h0000_9999;
      tick;
      dec_fc = 0; res_v = 0; res_mispred = 0;
      #1;
      chk("mid_rst_count", count, 0);
      chk("mid_rst_redir_v", redirect_v, 0);
      chk("mid_rst_pc", redirect_pc, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_tag", dec_tag, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/thor2024_fc_tracker.md
THOR2024_FC_TRACKER -- requirements
Module: thor2024_fc_tracker

Interface
REQ-001 Parameter DEPTH, default 4, number of outstanding flow-control (fc) entries; SHALL be a power of two, 2..16.
REQ-002 Parameter TAGW, default 2, tag width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 dec_v  input  1  decoded instruction valid this cycle.
REQ-006 dec_fc  input  1  flow-control flag from decoder (SYS, JSR, Bcc, BBC/BBS, RTD).
REQ-007 dec_rdy  output  1  decode may hand over; SHALL equal !dec_fc | (!full & !mis_hit), combinational.
REQ-008 dec_tag  output  TAGW  tag for an fc instruction accepted this cycle; SHALL equal tail pointer.
REQ-009 res_v  input  1  resolution report valid.
REQ-010 res_tag  input  TAGW  tag being resolved.
REQ-011 res_mispred  input  1  resolved entry was mispredicted.
REQ-012 res_tgt  input  32  correct target address on mispredict.
REQ-013 redirect_v  output  1  registered one-cycle fetch redirect pulse.
REQ-014 redirect_pc  output  32  registered redirect address; holds last value.
REQ-015 stall  output  1  SHALL equal full (count == DEPTH).
REQ-016 count  output  TAGW+1  number of valid entries.

Function
REQ-017 State: circular buffer of DEPTH entries, each {valid, done}; head, tail pointers (TAGW bits, wrap modulo DEPTH); count 0..DEPTH.
REQ-018 alloc = dec_v & dec_fc & dec_rdy; on alloc entry[tail] SHALL become valid=1, done=0 and tail SHALL increment, wrapping DEPTH-1 -> 0.
REQ-019 Non-fc instructions (dec_fc=0) SHALL never allocate or change state.
REQ-020 res_hit = res_v & entry[res_tag].valid; a resolution to a non-valid tag SHALL be ignored entirely.
REQ-021 On res_hit, entry[res_tag].done SHALL be set next cycle; resolutions may arrive in any order.
REQ-022 retire = entry[head].valid & entry[head].done (registered state); on retire entry[head] SHALL clear and head increment; at most one retire per cycle.
REQ-023 mis_hit = res_hit & res_mispred; on mis_hit all entries younger than res_tag (res_tag+1 up to tail-1, modulo DEPTH) SHALL be invalidated and tail SHALL become res_tag+1.
REQ-024 On mis_hit, redirect_v SHALL be 1 and redirect_pc SHALL equal res_tgt in the following cycle only; redirect_v otherwise 0.
REQ-025 Allocation SHALL be blocked in a mis_hit cycle (dec_rdy low for fc); mispredict wins over allocation.
REQ-026 count next = count + alloc - retire normally; on mis_hit count next = ((res_tag - head) mod DEPTH) + 1 - retire.
REQ-027 Retire and alloc in the same cycle SHALL both take effect; when full (count==DEPTH) no alloc that cycle even if retire occurs.
REQ-028 Retire of the head in the same cycle as mis_hit on a younger tag SHALL both take effect.
REQ-029 Latency: result of a resolution visible in done 1 cycle later; earliest retire 1 cycle after done set.
REQ-030 Two or more same-cycle events on one entry (res_hit and retire) cannot occur since retire requires done already set; a res_hit on an already-done entry SHALL be harmless (done stays 1, mispredict still honoured).

Reset
REQ-031 While rst_n=0 at a clock edge: head=0, tail=0, count=0, all valid/done=0, redirect_v=0, redirect_pc=0; hence stall=0, dec_tag=0.
REQ-032 Reset SHALL override any simultaneous alloc, resolution or retire; reset mid-operation discards all entries with no redirect issued.

Verification
REQ-033 Fill: 4 fc decodes back-to-back after reset -> dec_tag 0,1,2,3; count=4, stall=1, dec_rdy=0 for fc, dec_rdy=1 for non-fc.
REQ-034 Out-of-order resolve: entries 0..2 valid, resolve tag 2 then 1 then 0 (no mispredict) -> no retire until tag 0 done, then heads 0,1,2 retire on three consecutive cycles, count 3->0.
REQ-035 Mispredict: head=0, tail=0 after 4 allocs (full), res tag 1 mispred res_tgt=32'h0000_1A40 -> next cycle redirect_v=1, redirect_pc=32'h0000_1A40, tail=2, count=2, stall=0.
REQ-036 Mispredict collides with fc decode in same cycle -> dec_rdy=0, no allocation, tail from mispredict only.
REQ-037 Wrap: with DEPTH=4, allocate/retire 6 entries -> dec_tag sequence 0,1,2,3,0,1; stale res_v on tag 3 after its retire ignored, count unchanged.
REQ-038 Reset asserted with count=3 and res_v mispred same cycle -> next cycle count=0, redirect_v=0, redirect_pc=0.
